rc_sched_gen: RTL

- Parametrised round-constant and round-index generator for the cipher key schedule.
- Generalises the fixed 5-bit LFSR constant counter: configurable LFSR width, taps, seed and round count.
- Adds a start/enable/done handshake and reverse-direction (inverse LFSR) stepping for decryption schedules.
- Sits beside the key-schedule datapath. It drives rc_out and round_idx each round and flags completion to the round controller.

---
 rtl/rc_sched_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rc_sched_gen.sv
// ---------------------------------------------------------------------------
// rc_sched_gen
// Round-constant and round-index generator for the cipher key schedule.
// A parametrised Fibonacci LFSR produces one round constant per enabled
// round, stepping forward for encryption or backward (inverse LFSR) for
// decryption schedules. A start/en/done handshake frames each run.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      begin a run (priority over en, also aborts a run in progress)
//   dir_in     0 = forward step, 1 = inverse step; latched on start
//   seed_in    initial round constant; latched on start; must be nonzero
//   en         advance one round while running
//   rc_out     current round constant (registered)
//   round_idx  rounds completed in this run (registered)
//   rc_valid   high while a run is in progress (registered)
//   done       high once the run has completed, until the next start
// ---------------------------------------------------------------------------
module rc_sched_gen #(
    parameter int                  RC_WIDTH   = 5,
    parameter logic [RC_WIDTH-1:0] TAP_MASK   = 5'b10100,
    parameter int                  CNT_WIDTH  = 5,
    parameter int                  NUM_ROUNDS = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dir_in,
    input  logic [RC_WIDTH-1:0]  seed_in,
    input  logic                 en,
    output logic [RC_WIDTH-1:0]  rc_out,
    output logic [CNT_WIDTH-1:0] round_idx,
    output logic                 rc_valid,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index value seen before the final step of a run. When NUM_ROUNDS equals
    // 2**CNT_WIDTH the counter wraps to zero after that step.
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_ROUNDS - 1);
    localparam logic [CNT_WIDTH-1:0] IDX_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Even-parity reduction used for LFSR feedback.
    function automatic logic parity_of(input logic [RC_WIDTH-1:0] vec);
        return ^vec;
    endfunction

    // Forward step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [RC_WIDTH-1:0] fwd_step(input logic [RC_WIDTH-1:0] rc);
        return {rc[RC_WIDTH-2:0], parity_of(rc & TAP_MASK)};
    endfunction

    // Inverse step: the bit that fell off the top is recovered from the
    // feedback bit (rc[0]) and the remaining taps, one position lower. The
    // top tap being set is what makes this recovery exact.
    function automatic logic [RC_WIDTH-1:0] inv_step(input logic [RC_WIDTH-1:0] rc);
        logic [RC_WIDTH-1:0] low_taps;
        low_taps = {1'b0, rc[RC_WIDTH-1:1] & TAP_MASK[RC_WIDTH-2:0]};
        return {rc[0] ^ parity_of(low_taps), rc[RC_WIDTH-1:1]};
    endfunction

    state_t                 state_r, state_s;
    logic [RC_WIDTH-1:0]    rc_r, rc_s;
    logic [CNT_WIDTH-1:0]   idx_r, idx_s;
    logic                   dir_r, dir_s;
    logic                   rc_valid_r;
    logic                   done_r;

    // Next-state and datapath update; start always wins over en.
    always_comb begin
        state_s = state_r;
        rc_s    = rc_r;
        idx_s   = idx_r;
        dir_s   = dir_r;
        if (start) begin
            rc_s    = seed_in;
            idx_s   = {CNT_WIDTH{1'b0}};
            dir_s   = dir_in;
            state_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (en) begin
                        if (dir_r) begin
                            rc_s = inv_step(rc_r);
                        end else begin
                            rc_s = fwd_step(rc_r);
                        end
                        idx_s = idx_r + IDX_ONE;
                        if (idx_r == LAST_IDX) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DONE: state_s = ST_DONE;
                ST_IDLE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, datapath and status-flag registers; flags are decoded from the
    // next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            rc_r       <= {RC_WIDTH{1'b0}};
            idx_r      <= {CNT_WIDTH{1'b0}};
            dir_r      <= 1'b0;
            rc_valid_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            rc_r       <= rc_s;
            idx_r      <= idx_s;
            dir_r      <= dir_s;
            rc_valid_r <= (state_s == ST_RUN);
            done_r     <= (state_s == ST_DONE);
        end
    end

    assign rc_out    = rc_r;
    assign round_idx = idx_r;
    assign rc_valid  = rc_valid_r;
    assign done      = done_r;

endmodule
